lane_merger: RTL

LANE_MERGER -- requirements
Module: lane_merger

---
 rtl/lane_merger.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/lane_merger.sv
// Two-lane byte deskew and merge: per-lane FIFOs absorb skew, pairs pop as 16-bit words.
// Optional sticky overflow flag enabled by defining LANE_MERGE_ERR_EN.
module lane_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [7:0]               data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [7:0]               head_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0][7:0] mem_q;
  logic [AW-1:0]         rd_q, wr_q;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  accept;

  // A full FIFO still takes a byte when the head leaves on the same edge.
  assign accept  = push_i && ((cnt_q != CW'(DEPTH)) || pop_i);
  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (accept && !pop_i)      cnt_d = cnt_q + CW'(1);
    else if (!accept && pop_i) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (accept) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (pop_i) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_d;
    end
  end
endmodule

module lane_merger #(
  parameter int SKEW_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  lane0_data,
  input  logic        lane0_valid,
  input  logic [7:0]  lane1_data,
  input  logic        lane1_valid,
  output logic [15:0] dout,
  output logic        dout_valid,
  output logic        err
);
  localparam int NUM_LANES = 2;
  localparam int CW        = $clog2(SKEW_DEPTH) + 1;

  logic [NUM_LANES-1:0][7:0]    lane_data, head;
  logic [NUM_LANES-1:0]         lane_vld, nonempty;
  logic [NUM_LANES-1:0][CW-1:0] count;
  logic                         pop, flush;
  logic [CW-1:0]                idle_q, idle_d;
  logic [15:0]                  dout_q;
  logic                         dout_valid_q;

  assign lane_data = {lane1_data, lane0_data};
  assign lane_vld  = {lane1_valid, lane0_valid};

  generate
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      lane_fifo #(.DEPTH(SKEW_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (lane_vld[l]),
        .data_i  (lane_data[l]),
        .pop_i   (pop),
        .flush_i (flush),
        .head_o  (head[l]),
        .count_o (count[l])
      );
      assign nonempty[l] = (count[l] != '0);
    end
  endgenerate

  assign pop = &nonempty;

  // Idle run length saturates at SKEW_DEPTH; reaching it marks packet end.
  always_comb begin
    idle_d = idle_q;
    if (|lane_vld)                     idle_d = '0;
    else if (idle_q != CW'(SKEW_DEPTH)) idle_d = idle_q + CW'(1);
  end

  assign flush = (idle_d == CW'(SKEW_DEPTH)) && !pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idle_q       <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      idle_q       <= idle_d;
      dout_valid_q <= pop;
      if (pop) dout_q <= {head[1], head[0]};
    end
  end

`ifdef LANE_MERGE_ERR_EN
  logic [NUM_LANES-1:0] drop;
  logic                 err_q;

  always_comb begin
    drop = '0;
    for (int l = 0; l < NUM_LANES; l++)
      drop[l] = lane_vld[l] && (count[l] == CW'(SKEW_DEPTH)) && !pop;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     err_q <= 1'b0;
    else if (|drop) err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
endmodule
